// File: rtl/gcore_pkg.sv
// gcore_pkg: shared opcodes, FSM state encoding and instruction decode helpers
// for the GCore accumulator core.
// Optional feature macro: GCORE_CALL_EN (opcode E = CALL, F = RET).
package gcore_pkg;

  localparam int unsigned OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_NOP  = 4'h0;
  localparam op_t OP_LDI  = 4'h1;
  localparam op_t OP_LD   = 4'h2;
  localparam op_t OP_ST   = 4'h3;
  localparam op_t OP_ADD  = 4'h4;
  localparam op_t OP_SUB  = 4'h5;
  localparam op_t OP_AND  = 4'h6;
  localparam op_t OP_OR   = 4'h7;
  localparam op_t OP_XOR  = 4'h8;
  localparam op_t OP_SHI  = 4'h9;
  localparam op_t OP_JMP  = 4'hA;
  localparam op_t OP_BZ   = 4'hB;
  localparam op_t OP_BNZ  = 4'hC;
  localparam op_t OP_HLT  = 4'hD;
  localparam op_t OP_CALL = 4'hE;
  localparam op_t OP_RET  = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_MEM    = 3'd2,
    ST_EXEC   = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

  // Jump taken in EXEC: target comes from MDR.
  function automatic logic op_takes_jump(input op_t op, input logic zero);
    logic taken;
    taken = 1'b0;
    case (op)
      OP_JMP:  taken = 1'b1;
      OP_BZ:   taken = zero;
      OP_BNZ:  taken = ~zero;
`ifdef GCORE_CALL_EN
      OP_CALL: taken = 1'b1;
`endif
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Operand m is needed; untaken branches skip the data read.
  function automatic logic op_uses_mem(input op_t op, input logic zero);
    logic uses;
    uses = 1'b0;
    case (op)
      OP_LD, OP_ST, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: uses = 1'b1;
      default: uses = op_takes_jump(op, zero);
    endcase
    return uses;
  endfunction

  // Instruction writes acc (and hence the zero flag).
  function automatic logic op_writes_acc(input op_t op);
    logic wr;
    wr = 1'b0;
    case (op)
      OP_LDI, OP_LD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHI: wr = 1'b1;
      default: wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/gcore_if.sv
// gcore_if: instruction and data memory req/ack buses of the GCore core.
//   master (core):   drives imem_req/imem_addr, dmem_req/we/addr/wdata
//   slave  (memory): drives imem_rdata/imem_ack, dmem_rdata/dmem_ack
// A transfer completes on the rising edge where req and ack are both high.
interface gcore_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IMM_W  = 4
) ();

  localparam int unsigned INSTR_W = gcore_pkg::OP_W + IMM_W;

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  logic               dmem_req;
  logic               dmem_we;
  logic [IMM_W-1:0]   dmem_addr;
  logic [DATA_W-1:0]  dmem_wdata;
  logic [DATA_W-1:0]  dmem_rdata;
  logic               dmem_ack;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdata, imem_ack,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdata, imem_ack,
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );

endinterface

// File: rtl/gcore_alu.sv
// gcore_alu: combinational accumulator datapath for LDI/LD and ADD..SHI.
//   op     in  opcode
//   acc    in  current accumulator
//   m      in  memory operand (MDR)
//   imm    in  instruction operand field
//   result out new accumulator value (acc for opcodes that do not write it)
module gcore_alu
  import gcore_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMM_W  = 4
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] m,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] imm_ext;

  assign imm_ext = DATA_W'(imm);

  // All arithmetic wraps modulo 2^DATA_W; no carry is kept.
  always_comb begin
    result = acc;
    case (op)
      OP_LDI:  result = imm_ext;
      OP_LD:   result = m;
      OP_ADD:  result = acc + m;
      OP_SUB:  result = acc - m;
      OP_AND:  result = acc & m;
      OP_OR:   result = acc | m;
      OP_XOR:  result = acc ^ m;
      OP_SHI:  result = (acc << IMM_W) | imm_ext;
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/gcore_core.sv
// gcore_core: single-clock multicycle GCore accumulator CPU.
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   run       in   fetch enable, checked only in FETCH
//   bus       if   gcore_if.master: imem and dmem req/ack buses
//   acc_out   out  accumulator
//   pc_out    out  program counter
//   zero_out  out  zero flag
//   halted    out  core is in HALT
// Optional feature macro: GCORE_CALL_EN adds CALL/RET and a link register.
// DATA_W must be greater than IMM_W.
module gcore_core
  import gcore_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned IMM_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  gcore_if.master           bus,
  output logic [DATA_W-1:0] acc_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              zero_out,
  output logic              halted
);

  localparam int unsigned INSTR_W = OP_W + IMM_W;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic               zero_q, zero_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0]  mdr_q, mdr_d;
`ifdef GCORE_CALL_EN
  logic [ADDR_W-1:0]  link_q, link_d;
`endif

  op_t                op;
  logic [IMM_W-1:0]   imm;
  logic [DATA_W-1:0]  alu_result;
  logic               imem_req_c, dmem_req_c, dmem_we_c;
  logic               fetch_done, mem_done;

  assign op  = ir_q[INSTR_W-1:IMM_W];
  assign imm = ir_q[IMM_W-1:0];

  assign fetch_done = imem_req_c & bus.imem_ack;
  assign mem_done   = dmem_req_c & bus.dmem_ack;

  gcore_alu #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_alu (
    .op     (op),
    .acc    (acc_q),
    .m      (mdr_q),
    .imm    (imm),
    .result (alu_result)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_FETCH;
    else      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (fetch_done) state_d = ST_DECODE;
      ST_DECODE: begin
        if (op == OP_HLT)               state_d = ST_HALT;
        else if (op_uses_mem(op, zero_q)) state_d = ST_MEM;
        else                            state_d = ST_EXEC;
      end
      ST_MEM:    if (mem_done) state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Moore outputs decoded from the state register; the fetch request is also
  // gated by rst so nothing is requested while reset is held.
  always_comb begin
    imem_req_c = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    halted     = 1'b0;
    case (state_q)
      ST_FETCH: imem_req_c = run & rst;
      ST_MEM: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = (op == OP_ST);
      end
      ST_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state: IR/PC on fetch, MDR on data ack, results in EXEC.
  always_comb begin
    pc_d   = pc_q;
    acc_d  = acc_q;
    zero_d = zero_q;
    ir_d   = ir_q;
    mdr_d  = mdr_q;
`ifdef GCORE_CALL_EN
    link_d = link_q;
`endif
    if (fetch_done) begin
      ir_d = bus.imem_rdata;
      pc_d = pc_q + ADDR_W'(1);
    end
    if (mem_done) mdr_d = bus.dmem_rdata;
    if (state_q == ST_EXEC) begin
      if (op_writes_acc(op)) begin
        acc_d  = alu_result;
        zero_d = (alu_result == '0);
      end
      // Target is truncated or zero-extended to the pc width.
      if (op_takes_jump(op, zero_q)) pc_d = ADDR_W'(mdr_q);
`ifdef GCORE_CALL_EN
      if (op == OP_CALL) link_d = pc_q;
      if (op == OP_RET)  pc_d   = link_q;
`endif
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= '0;
      acc_q  <= '0;
      zero_q <= 1'b1;
      ir_q   <= '0;
      mdr_q  <= '0;
`ifdef GCORE_CALL_EN
      link_q <= '0;
`endif
    end else begin
      pc_q   <= pc_d;
      acc_q  <= acc_d;
      zero_q <= zero_d;
      ir_q   <= ir_d;
      mdr_q  <= mdr_d;
`ifdef GCORE_CALL_EN
      link_q <= link_d;
`endif
    end
  end

  assign bus.imem_req   = imem_req_c;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_c;
  assign bus.dmem_we    = dmem_we_c;
  assign bus.dmem_addr  = imm;
  assign bus.dmem_wdata = acc_q;

  assign acc_out  = acc_q;
  assign pc_out   = pc_q;
  assign zero_out = zero_q;

endmodule

// File: tb/tb_gcore_core.sv
// tb_gcore_core: directed bench for gcore_core with wait-state memory models
// and a retirement scoreboard (acc/pc/zero/latency per instruction).
module tb_gcore_core;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned IMM_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic [DATA_W-1:0] acc_out;
  logic [ADDR_W-1:0] pc_out;
  logic              zero_out;
  logic              halted;

  gcore_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) bus ();

  gcore_core #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .bus      (bus),
    .acc_out  (acc_out),
    .pc_out   (pc_out),
    .zero_out (zero_out),
    .halted   (halted)
  );

  always #5 clk = ~clk;

  // ---------------- memory models ----------------
  logic [7:0] imem      [256];
  logic [7:0] dmem      [16];
  logic [7:0] dmem_init [16];
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;

  assign bus.imem_ack   = bus.imem_req && (icnt >= imem_wait);
  assign bus.imem_rdata = imem[bus.imem_addr];
  assign bus.dmem_ack   = bus.dmem_req && (dcnt >= dmem_wait);
  assign bus.dmem_rdata = dmem[bus.dmem_addr];

  always @(posedge clk) begin
    icnt <= (bus.imem_req && !bus.imem_ack) ? icnt + 1 : 0;
    dcnt <= (bus.dmem_req && !bus.dmem_ack) ? dcnt + 1 : 0;
    if (!rst) begin
      for (int i = 0; i < 16; i++) dmem[i] = dmem_init[i];
    end else if (bus.dmem_req && bus.dmem_ack && bus.dmem_we) begin
      dmem[bus.dmem_addr] = bus.dmem_wdata;
    end
  end

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic [7:0] acc;
    logic [7:0] pc;
    logic       zero;
    int         lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic push(input int id, input logic [7:0] acc, input logic [7:0] pc,
                      input logic zero, input int lat);
    exp_t e;
    e.id = id; e.acc = acc; e.pc = pc; e.zero = zero; e.lat = lat;
    sb_q.push_back(e);
  endtask

  int   cyc = 0;
  int   last_rise = 0;
  bit   started = 1'b0;
  int   ireq_cycles = 0;
  int   dreq_cycles = 0;
  int   dxfers = 0;
  int   stab_err = 0;
  logic p_ireq = 1'b0, p_iack = 1'b0, p_dreq = 1'b0, p_dack = 1'b0, p_dwe = 1'b0;
  logic [7:0] p_iaddr = '0, p_dwdata = '0;
  logic [3:0] p_daddr = '0;

  // A new fetch request rising means the previous instruction has retired.
  always @(negedge clk) begin
    if (!rst) begin
      started = 1'b0;
      p_ireq  = 1'b0; p_iack = 1'b0;
      p_dreq  = 1'b0; p_dack = 1'b0;
    end else begin
      cyc++;
      if (bus.imem_req) ireq_cycles++;
      if (bus.dmem_req) dreq_cycles++;
      if (bus.dmem_req && bus.dmem_ack) dxfers++;
      if (p_ireq && !p_iack && (!bus.imem_req || bus.imem_addr !== p_iaddr)) stab_err++;
      if (p_dreq && !p_dack && (!bus.dmem_req || bus.dmem_we !== p_dwe ||
          bus.dmem_addr !== p_daddr || bus.dmem_wdata !== p_dwdata)) stab_err++;
      if (bus.imem_req && !p_ireq) begin
        if (started) begin
          chk("sb_pending", 32'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk($sformatf("acc#%0d", mon_e.id),  32'(acc_out),  32'(mon_e.acc));
            chk($sformatf("pc#%0d", mon_e.id),   32'(pc_out),   32'(mon_e.pc));
            chk($sformatf("zero#%0d", mon_e.id), 32'(zero_out), 32'(mon_e.zero));
            chk($sformatf("lat#%0d", mon_e.id),  32'(cyc - last_rise), 32'(mon_e.lat));
          end
        end
        started   = 1'b1;
        last_rise = cyc;
      end
      p_ireq = bus.imem_req;  p_iack = bus.imem_ack;  p_iaddr = bus.imem_addr;
      p_dreq = bus.dmem_req;  p_dack = bus.dmem_ack;  p_dwe = bus.dmem_we;
      p_daddr = bus.dmem_addr; p_dwdata = bus.dmem_wdata;
    end
  end

  task automatic wait_halt(input int max);
    for (int i = 0; i < max && !halted; i++) @(negedge clk);
    chk("halt_reached", 32'(halted), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int b_i, b_d, b_x, b_s;
    rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 8'hD0;
    for (int i = 0; i < 16; i++) dmem_init[i] = 8'h00;
    dmem_init[1] = 8'h40; dmem_init[2] = 8'h10; dmem_init[3] = 8'hF0;
    dmem_init[4] = 8'h20; dmem_init[5] = 8'h3C; dmem_init[6] = 8'h81;
    dmem_init[8] = 8'h50;
    imem[8'h00] = 8'h15; imem[8'h01] = 8'h22; imem[8'h02] = 8'h43;
    imem[8'h03] = 8'hC4; imem[8'h04] = 8'hB4; imem[8'h20] = 8'h52;
    imem[8'h21] = 8'hB4; imem[8'h22] = 8'h37; imem[8'h23] = 8'h1A;
    imem[8'h24] = 8'h9B; imem[8'h25] = 8'h9C; imem[8'h26] = 8'h65;
    imem[8'h27] = 8'h76; imem[8'h28] = 8'h86; imem[8'h29] = 8'h85;
    imem[8'h2A] = 8'h00; imem[8'h2B] = 8'hE1; imem[8'h2D] = 8'hA8;
`ifdef GCORE_CALL_EN
    imem[8'h2C] = 8'h00; imem[8'h40] = 8'hF0;
`else
    imem[8'h2C] = 8'hF0;
`endif
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    // Reset state, with run high to show no request leaks out in reset.
    chk("rst_pc",       32'(pc_out), 0);
    chk("rst_acc",      32'(acc_out), 0);
    chk("rst_zero",     32'(zero_out), 1);
    chk("rst_halted",   32'(halted), 0);
    chk("rst_imem_req", 32'(bus.imem_req), 0);
    chk("rst_dmem_req", 32'(bus.dmem_req), 0);
    chk("rst_dmem_we",  32'(bus.dmem_we), 0);

    // Program A: zero-wait memories, every opcode, wrap-around and branches.
    push(0,  8'h05, 8'h01, 1'b0, 3);
    push(1,  8'h10, 8'h02, 1'b0, 4);
    push(2,  8'h00, 8'h03, 1'b1, 4);
    push(3,  8'h00, 8'h04, 1'b1, 3);
    push(4,  8'h00, 8'h20, 1'b1, 4);
    push(5,  8'hF0, 8'h21, 1'b0, 4);
    push(6,  8'hF0, 8'h22, 1'b0, 3);
    push(7,  8'hF0, 8'h23, 1'b0, 4);
    push(8,  8'h0A, 8'h24, 1'b0, 3);
    push(9,  8'hAB, 8'h25, 1'b0, 3);
    push(10, 8'hBC, 8'h26, 1'b0, 3);
    push(11, 8'h3C, 8'h27, 1'b0, 4);
    push(12, 8'hBD, 8'h28, 1'b0, 4);
    push(13, 8'h3C, 8'h29, 1'b0, 4);
    push(14, 8'h00, 8'h2A, 1'b1, 4);
    push(15, 8'h00, 8'h2B, 1'b1, 3);
`ifdef GCORE_CALL_EN
    push(16, 8'h00, 8'h40, 1'b1, 4);
    push(17, 8'h00, 8'h2C, 1'b1, 3);
    push(18, 8'h00, 8'h2D, 1'b1, 3);
`else
    push(16, 8'h00, 8'h2C, 1'b1, 3);
    push(17, 8'h00, 8'h2D, 1'b1, 3);
`endif
    push(19, 8'h00, 8'h50, 1'b1, 4);
    b_x = dxfers;
    @(posedge clk); #2 rst = 1'b1;
    wait_halt(400);
    chk("a_sb_drained", 32'(sb_q.size()), 0);
    chk("a_st_mem7",    32'(dmem[7]), 32'h0F0);
`ifdef GCORE_CALL_EN
    chk("a_dxfers",     32'(dxfers - b_x), 11);
`else
    chk("a_dxfers",     32'(dxfers - b_x), 10);
`endif
    chk("a_halt_pc",    32'(pc_out), 32'h51);
    b_i = ireq_cycles; b_d = dreq_cycles;
    repeat (20) @(negedge clk);
    chk("halt_no_ireq", 32'(ireq_cycles - b_i), 0);
    chk("halt_no_dreq", 32'(dreq_cycles - b_d), 0);
    chk("halt_stays",   32'(halted), 1);

    // Program B: run held low, then wait states on both buses around ST 7.
    #2 rst = 1'b0; run = 1'b0;
    imem_wait = 3; dmem_wait = 2;
    for (int i = 0; i < 256; i++) imem[i] = 8'hD0;
    imem[0] = 8'h19; imem[1] = 8'h37;
    dmem_init[7] = 8'h00;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst = 1'b1;
    b_i = ireq_cycles; b_d = dreq_cycles; b_x = dxfers; b_s = stab_err;
    repeat (5) @(negedge clk);
    chk("b_idle_no_ireq", 32'(ireq_cycles - b_i), 0);
    chk("b_idle_pc",      32'(pc_out), 0);
    push(100, 8'h09, 8'h01, 1'b0, 6);
    push(101, 8'h09, 8'h02, 1'b0, 9);
    @(posedge clk); #2 run = 1'b1;
    wait_halt(200);
    chk("b_sb_drained",  32'(sb_q.size()), 0);
    chk("b_st_mem7",     32'(dmem[7]), 32'h09);
    chk("b_stable",      32'(stab_err - b_s), 0);
    chk("b_dxfers",      32'(dxfers - b_x), 1);
    chk("b_dreq_cycles", 32'(dreq_cycles - b_d), 3);
    chk("b_ireq_cycles", 32'(ireq_cycles - b_i), 12);

    // Program C: reset asserted while ST waits in MEM.
    #2 rst = 1'b0;
    imem_wait = 0; dmem_wait = 6;
    for (int i = 0; i < 256; i++) imem[i] = 8'hD0;
    imem[0] = 8'h13; imem[1] = 8'h33;
    dmem_init[3] = 8'h55;
    repeat (2) @(negedge clk);
    push(200, 8'h03, 8'h01, 1'b0, 3);
    @(posedge clk); #2 rst = 1'b1;
    for (int i = 0; i < 50 && !bus.dmem_req; i++) @(negedge clk);
    chk("c_dreq_seen", 32'(bus.dmem_req), 1);
    chk("c_dwe_seen",  32'(bus.dmem_we), 1);
    @(posedge clk); #2 rst = 1'b0;
    #1;
    chk("c_rst_dreq",  32'(bus.dmem_req), 0);
    chk("c_rst_dwe",   32'(bus.dmem_we), 0);
    chk("c_rst_ireq",  32'(bus.imem_req), 0);
    chk("c_rst_pc",    32'(pc_out), 0);
    chk("c_rst_acc",   32'(acc_out), 0);
    chk("c_rst_zero",  32'(zero_out), 1);
    chk("c_no_write",  32'(dmem[3]), 32'h55);
    chk("c_sb_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/gcore_core.md
# gcore_core

Parametrised single-clock successor to the GCore accumulator CPU. The phase-clock scheme (separate pc/opram/mem/acc clocks) is replaced by one clock and a multicycle FSM. Instruction and data memories sit outside the core behind req/ack handshakes, so wait-state memories work. Debug taps (acc, pc, halted) feed the board LED block.

## Interface
- DATA_W, 8: accumulator and data-memory word width; must be greater than IMM_W.
- ADDR_W, 8: program counter and instruction-address width.
- IMM_W, 4: operand field width and data-memory address width; opcode is fixed at 4 bits, INSTR_W = 4 + IMM_W.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  when low, the core idles in FETCH without issuing a request.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address, equal to pc.
- imem_rdata  in  INSTR_W  instruction; sampled on the cycle imem_ack is high.
- imem_ack  in  1  fetch completes on the edge where req and ack are both high.
- dmem_req  out  1  data request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  IMM_W  operand field of the instruction.
- dmem_wdata  out  DATA_W  equal to acc.
- dmem_rdata  in  DATA_W  read data, valid with dmem_ack.
- dmem_ack  in  1  data transfer completes on the edge where req and ack are both high.
- acc_out  out  DATA_W  accumulator.
- pc_out  out  ADDR_W  program counter.
- zero_out  out  1  zero flag.
- halted  out  1  core is in the HALT state.

## Operation
- Instruction format: opcode is bits [INSTR_W-1:IMM_W]; imm is bits [IMM_W-1:0]. The notation m means mem[imm].
- Opcodes:
  - 0 NOP.
  - 1 LDI: acc = zext(imm).
  - 2 LD: acc = m.
  - 3 ST: m = acc.
  - 4 ADD: acc = acc + m.
  - 5 SUB: acc = acc - m.
  - 6 AND.
  - 7 OR.
  - 8 XOR.
  - 9 SHI: acc = (acc << IMM_W) | imm.
  - A JMP: pc = m.
  - B BZ: if zero, pc = m.
  - C BNZ: if not zero, pc = m.
  - D HLT.
  - E and F: NOP unless the call feature is compiled in (see Configuration).
- Arithmetic: all results are modulo 2^DATA_W; there is no carry or overflow flag.
- Zero flag: registered. Every acc write sets it to (new acc == 0). ST, NOP and branches leave it unchanged.
- Jump target width: m is truncated to ADDR_W bits, or zero-extended if ADDR_W > DATA_W.
- PC: pc is incremented modulo 2^ADDR_W when the fetch completes. A taken jump overrides the increment in EXEC.
- States and transitions:
  - FETCH: if run = 1, assert imem_req and hold it until ack; on ack, latch IR, increment pc, go to DECODE. If run = 0, stay in FETCH with req low.
  - DECODE: go to MEM if the opcode uses m (LD, ST, ALU ops, JMP, taken BZ/BNZ, CALL); go to HALT on HLT; otherwise go to EXEC.
  - MEM: hold dmem_req, dmem_we, dmem_addr and dmem_wdata stable until ack; latch read data into MDR; go to EXEC.
  - EXEC: write acc, zero and pc as required; go to FETCH.
  - HALT: terminal state with no requests; only rst leaves it.
- Untaken branch: BZ/BNZ with the condition false skip MEM and issue no data read.
- run low mid-instruction: the current instruction completes; run is checked only in FETCH.

## Timing
- Reset values (applied asynchronously):
  - pc = 0, acc = 0, zero = 1.
  - All req outputs = 0, dmem_we = 0, halted = 0.
  - State = FETCH.
- Reset mid-transaction drops all requests immediately. No partial write is committed by the core.
- Zero-wait memories (ack tied to req):
  - Non-memory instructions take 3 cycles (FETCH, DECODE, EXEC).
  - Memory instructions take 4 cycles (FETCH, DECODE, MEM, EXEC).
- Each wait cycle adds 1 cycle. Addresses, we and wdata are stable while req is high.
- req deasserts in the cycle after the ack edge.
- acc_out, pc_out and zero_out update on the EXEC edge; pc_out also updates on the FETCH-ack edge.

## Configuration
- GCORE_CALL_EN defined:
  - E CALL: link = pc (already incremented), then pc = m.
  - F RET: pc = link.
  - link is a single ADDR_W register, reset to 0; a nested CALL overwrites it.
- GCORE_CALL_EN undefined: E and F are NOPs, and no link register is built.

## Structure
- gcore_pkg holds:
  - opcode localparams;
  - FSM state encoding (FETCH, DECODE, MEM, EXEC, HALT);
  - an op-uses-memory decode function.
- gcore_alu is a combinational sub-module with inputs op, acc, m and imm, and output result. It covers ADD through SHI plus LD/LDI pass-through.

## Test plan
- Reset, then LDI 5, zero-wait memories -> 3 cycles later acc = 5, zero = 0, pc = 1.
- Wrap-around, DATA_W = 8, mem[2] = 0x10, mem[3] = 0xF0. Run LD 2; ADD 3 -> acc = 0x00, zero = 1. Then SUB 2 -> acc = 0xF0, zero = 0.
- Branches, with zero = 1 and mem[4] = 0x20:
  - BZ 4 -> pc = 0x20, one data read.
  - BNZ 4 -> pc = old pc + 1, dmem_req never asserted.
- Wait states: imem_ack delayed 3 cycles and dmem_ack delayed 2 on ST 7 -> req and address held stable throughout, the instruction takes 9 cycles, and mem[7] = acc.
- Wide constant, DATA_W = 16, IMM_W = 4: LDI A; SHI B; SHI C -> acc = 0x0ABC.
- HLT -> halted = 1 with no further requests for 20 cycles. Reset asserted mid-MEM -> dmem_req low in the same cycle, pc = 0.
- With GCORE_CALL_EN defined, mem[1] = 0x40: CALL 1 at pc 3 -> pc = 0x40, link = 4; RET -> pc = 4.
